alu_cmd_issuer: RTL
===================

# alu_cmd_issuer

Sequential front-end for the team's combinational 16-bit ALU. Accepts operation commands over a valid/ready handshake and registers their operands. Drives the ALU's opcode/operand/carry-in pins for one pass (narrow) or two passes (wide, 32-bit), then captures the result word, zero/negative flags and a derived carry. It sits between the command source (controller or testbench) and the ALU; the ALU itself stays external.

## Interface
- No parameters; widths fixed: ALU word 16, wide word 32, opcode 3.
- clk  in  1  single clock, rising edge
- rst  in  1  reset, synchronous, active-high
- cmd_valid  in  1  command present
- cmd_ready  out  1  issuer can accept (high only in IDLE)
- cmd_op  in  3  ALU opcode (000 neg, 001 inc, 010 add, 011 a+b/2, 100 and, 101 or, 110 concat)
- cmd_wide  in  1  1 = 32-bit two-pass op
- cmd_a, cmd_b  in  32  operands (narrow uses [15:0])
- cmd_inc  in  1  carry-in for narrow add / low pass of wide add
- alu_opc  out  3  to ALU
- alu_ina, alu_inb  out  16  to ALU
- alu_inc  out  1  to ALU
- alu_w  in  16  from ALU
- alu_zer, alu_neg  in  1  from ALU
- res_valid  out  1  result held
- res_ready  in  1  consumer takes result
- res_data  out  32  result (narrow: upper 16 zero)
- res_zer, res_neg, res_carry  out  1  result flags

## Operation
- States: IDLE, LO, HI, DONE. Reset → IDLE; all registered outputs 0. IDLE-state ALU drive is alu_opc=111, ina/inb=0, inc=0, so the ALU outputs 0.
- IDLE: cmd_ready=1. On cmd_valid: latch op, wide, a, b, inc → LO.
- Wide is honoured only for op 001, 010, 100, 101. For any other op, cmd_wide is ignored and the op runs narrow.
- LO: drive alu_opc=op, ina=a[15:0], inb=b[15:0], inc=(op==010 ? inc : 0). Capture alu_w into res_data[15:0] and carry_lo. Narrow → DONE; wide → HI.
- HI: high-half drive per op:
  - Op 010: opc 010, ina=a[31:16], inb=b[31:16], inc=carry_lo.
  - Op 001: opc 010, ina=a[31:16], inb=0, inc=carry_lo.
  - Op 100/101: opc unchanged, high halves, inc=0.
  - Capture into res_data[31:16] → DONE.
- Carry rule per pass:
  - op 010: carry = (w < ina) | (inc & w == ina), unsigned compare.
  - op 001: carry = (ina == 16'hFFFF).
  - Otherwise 0.
  - res_carry = carry of the last pass.
- Flags:
  - Narrow: res_zer = alu_zer, res_neg = alu_neg from the LO pass.
  - Wide: res_zer = zer_lo & zer_hi; res_neg = HI-pass alu_neg.
- DONE: res_valid=1; res_* stable. On res_ready → IDLE, and res_valid drops the next cycle. No new command is accepted in DONE.
- rst in any state aborts the operation at the next edge: IDLE, res_valid=0, res_* = 0, partial results are discarded.

## Timing
- Accept at edge T (cmd_valid & cmd_ready). LO occupies cycle T→T+1.
- Narrow: res_valid high from T+1. Wide: res_valid high from T+2.
- ALU outputs are sampled at the end of the same cycle the issuer drives them. The ALU path must close in one clock; there is no ALU output register.
- Throughput:
  - Narrow, res_ready tied high: 1 command per 3 cycles.
  - Wide, res_ready tied high: 1 command per 4 cycles.
- res_ready high in the first DONE cycle → DONE lasts exactly 1 cycle.
- cmd_valid asserted while busy is ignored. The source must hold it until cmd_ready.

## Structure
- Package alu_pkg:
  - opcode localparams: OP_NEG, OP_INC, OP_ADD, OP_ADDHALF, OP_AND, OP_OR, OP_CAT, OP_NOP=3'b111
  - typedef enum for the state (IDLE, LO, HI, DONE)
  - function is_wide_capable(op)
- One sub-module is natural: alu_carry_calc (op, ina, inb, inc, w → carry), combinational and reused by the LO and HI passes.
- The ALU is not instantiated inside; the bench connects it.

## Test plan
- Narrow add: a=16'h7FFF, b=16'h0001, inc=0 → res_valid at T+1, res_data=32'h0000_8000, neg=1, zer=0, carry=0.
- Wide add with cross-half carry: a=32'h0000_FFFF, b=32'h0000_0001 → T+2, res_data=32'h0001_0000, carry=0, zer=0. Repeat with a=32'hFFFF_FFFF, b=1 → res_data=0, zer=1, carry=1.
- Wide increment: a=32'h1234_FFFF, op 001 → res_data=32'h1235_0000. Wide with op 110 → runs narrow, a=16'hAB.., b=16'h..CD → res_data[31:16]=0.
- Backpressure: res_ready=0 for 5 cycles → res_* stable, cmd_ready=0. A cmd_valid during the stall is not accepted. After res_ready=1, the next command is accepted the following cycle.
- Reset mid-HI: assert rst in HI → next edge IDLE, res_valid=0, res_data=0, ALU drive opc=111. A fresh narrow OR (a=16'hF0F0, b=16'h0F0F) then yields 16'hFFFF, neg=1.

Source files
------------

// File: rtl/alu_cmd_issuer_pkg.sv
`default_nettype none
// ============================================================================
// alu_pkg: opcodes, issuer state encoding and opcode helpers
// Rev 1.0
// ============================================================================
package alu_pkg;

  localparam logic [2:0] OP_NEG     = 3'b000;
  localparam logic [2:0] OP_INC     = 3'b001;
  localparam logic [2:0] OP_ADD     = 3'b010;
  localparam logic [2:0] OP_ADDHALF = 3'b011;
  localparam logic [2:0] OP_AND     = 3'b100;
  localparam logic [2:0] OP_OR      = 3'b101;
  localparam logic [2:0] OP_CAT     = 3'b110;
  localparam logic [2:0] OP_NOP     = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } state_e;

  function automatic logic is_wide_capable(input logic [2:0] op);
    return (op == OP_INC) || (op == OP_ADD) || (op == OP_AND) || (op == OP_OR);
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_cmd_issuer_if.sv
`default_nettype none
// ============================================================================
// alu_cmd_issuer_if: command, ALU-pin and result bundle of the issuer
// Rev 1.0
// ============================================================================
interface alu_cmd_issuer_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic        cmd_wide;
  logic [31:0] cmd_a;
  logic [31:0] cmd_b;
  logic        cmd_inc;

  logic [2:0]  alu_opc;
  logic [15:0] alu_ina;
  logic [15:0] alu_inb;
  logic        alu_inc;
  logic [15:0] alu_w;
  logic        alu_zer;
  logic        alu_neg;

  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;
  logic        res_zer;
  logic        res_neg;
  logic        res_carry;

  modport slave (
    input  cmd_valid, cmd_op, cmd_wide, cmd_a, cmd_b, cmd_inc,
    input  alu_w, alu_zer, alu_neg, res_ready,
    output cmd_ready, alu_opc, alu_ina, alu_inb, alu_inc,
    output res_valid, res_data, res_zer, res_neg, res_carry
  );

  modport master (
    output cmd_valid, cmd_op, cmd_wide, cmd_a, cmd_b, cmd_inc,
    output alu_w, alu_zer, alu_neg, res_ready,
    input  cmd_ready, alu_opc, alu_ina, alu_inb, alu_inc,
    input  res_valid, res_data, res_zer, res_neg, res_carry
  );
endinterface
`default_nettype wire

// File: rtl/alu_cmd_issuer_carry_calc.sv
`default_nettype none
// ============================================================================
// alu_carry_calc: carry-out of one ALU pass, derived from its pins and result
// Rev 1.0
// ============================================================================
module alu_carry_calc
  import alu_pkg::*;
(
  input  logic [2:0]  opc_i,
  input  logic [15:0] ina_i,
  input  logic        inc_i,
  input  logic [15:0] w_i,
  output logic        carry_o
);

  always_comb begin
    case (opc_i)
      // A wrapped sum is smaller than an addend, or equal when carry-in was set.
      OP_ADD:  carry_o = (w_i < ina_i) | (inc_i & (w_i == ina_i));
      OP_INC:  carry_o = (ina_i == 16'hFFFF);
      default: carry_o = 1'b0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/alu_cmd_issuer.sv
`default_nettype none
// ============================================================================
// alu_cmd_issuer: drives an external 16-bit ALU for one or two passes
// Rev 1.0
// ============================================================================
module alu_cmd_issuer
  import alu_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  alu_cmd_issuer_if.slave bus
);

  state_e      state_q, state_d;
  logic [2:0]  op_q, op_d;
  logic        wide_q, wide_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic        inc_q, inc_d;
  logic        carry_lo_q, carry_lo_d;
  logic [31:0] res_data_q, res_data_d;
  logic        res_zer_q, res_zer_d;
  logic        res_neg_q, res_neg_d;
  logic        res_carry_q, res_carry_d;

  logic [2:0]  drv_opc;
  logic [15:0] drv_ina;
  logic [15:0] drv_inb;
  logic        drv_inc;
  logic        pass_carry;

  always_comb begin
    drv_opc = OP_NOP;
    drv_ina = '0;
    drv_inb = '0;
    drv_inc = 1'b0;
    case (state_q)
      LO: begin
        drv_opc = op_q;
        drv_ina = a_q[15:0];
        drv_inb = b_q[15:0];
        drv_inc = (op_q == OP_ADD) ? inc_q : 1'b0;
      end
      HI: begin
        drv_ina = a_q[31:16];
        // The high half of an increment is an add of zero with the low carry.
        case (op_q)
          OP_ADD: begin
            drv_opc = OP_ADD;
            drv_inb = b_q[31:16];
            drv_inc = carry_lo_q;
          end
          OP_INC: begin
            drv_opc = OP_ADD;
            drv_inc = carry_lo_q;
          end
          default: begin
            drv_opc = op_q;
            drv_inb = b_q[31:16];
          end
        endcase
      end
      default: ;
    endcase
  end

  alu_carry_calc u_carry (
    .opc_i   (drv_opc),
    .ina_i   (drv_ina),
    .inc_i   (drv_inc),
    .w_i     (bus.alu_w),
    .carry_o (pass_carry)
  );

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    wide_d      = wide_q;
    a_d         = a_q;
    b_d         = b_q;
    inc_d       = inc_q;
    carry_lo_d  = carry_lo_q;
    res_data_d  = res_data_q;
    res_zer_d   = res_zer_q;
    res_neg_d   = res_neg_q;
    res_carry_d = res_carry_q;
    case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          state_d = LO;
          op_d    = bus.cmd_op;
          wide_d  = bus.cmd_wide & is_wide_capable(bus.cmd_op);
          a_d     = bus.cmd_a;
          b_d     = bus.cmd_b;
          inc_d   = bus.cmd_inc;
        end
      end
      LO: begin
        res_data_d  = {16'h0000, bus.alu_w};
        res_zer_d   = bus.alu_zer;
        res_neg_d   = bus.alu_neg;
        res_carry_d = pass_carry;
        carry_lo_d  = pass_carry;
        state_d     = wide_q ? HI : DONE;
      end
      HI: begin
        res_data_d  = {bus.alu_w, res_data_q[15:0]};
        res_zer_d   = res_zer_q & bus.alu_zer;
        res_neg_d   = bus.alu_neg;
        res_carry_d = pass_carry;
        state_d     = DONE;
      end
      DONE: begin
        if (bus.res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      op_q        <= '0;
      wide_q      <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      inc_q       <= 1'b0;
      carry_lo_q  <= 1'b0;
      res_data_q  <= '0;
      res_zer_q   <= 1'b0;
      res_neg_q   <= 1'b0;
      res_carry_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      wide_q      <= wide_d;
      a_q         <= a_d;
      b_q         <= b_d;
      inc_q       <= inc_d;
      carry_lo_q  <= carry_lo_d;
      res_data_q  <= res_data_d;
      res_zer_q   <= res_zer_d;
      res_neg_q   <= res_neg_d;
      res_carry_q <= res_carry_d;
    end
  end

  assign bus.cmd_ready = (state_q == IDLE);
  assign bus.res_valid = (state_q == DONE);
  assign bus.res_data  = res_data_q;
  assign bus.res_zer   = res_zer_q;
  assign bus.res_neg   = res_neg_q;
  assign bus.res_carry = res_carry_q;
  assign bus.alu_opc   = drv_opc;
  assign bus.alu_ina   = drv_ina;
  assign bus.alu_inb   = drv_inb;
  assign bus.alu_inc   = drv_inc;

endmodule
`default_nettype wire
